// File: rtl/mba_instr_prefetch.sv
// Instruction prefetch stage: sequential word fetch from the instruction RAM wrapper
// into a small address-tagged FIFO, drained by decode over valid/ready, with redirect flush.
module mba_instr_prefetch #(
    parameter int                    RAM_SIZE   = 32768,
    parameter int                    ADDR_WIDTH = $clog2(RAM_SIZE) + 1,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 'h8000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  branch_i,
    input  logic [ADDR_WIDTH-1:0] branch_addr_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  busy_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int                    PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                    CNT_W     = PTR_W + 1;
    localparam logic [CNT_W:0]        DEPTH_V   = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~(ADDR_WIDTH'(3));
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [ADDR_WIDTH-1:0] pend_addr_q;
    logic                  pending_q;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];

    logic [CNT_W:0] occupancy;
    logic           issue;
    logic           push;
    logic           pop;

    // In-flight response reserves a slot; a same-cycle pop is deliberately not credited.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, pending_q};
    assign issue     = req_i & ~branch_i & ~rst & (occupancy < DEPTH_V);
    assign push      = pending_q & ~branch_i;
    assign pop       = instr_valid_o & instr_ready_i & ~branch_i;

    assign instr_valid_o = (count != '0);
    assign busy_o        = pending_q | instr_valid_o;
    assign mem_en_o      = issue;
    assign mem_addr_o    = fetch_addr;
    assign instr_rdata_o = data_mem[rd_ptr];
    assign instr_addr_o  = addr_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_addr  <= BOOT_ADDR;
            pend_addr_q <= '0;
            pending_q   <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            pending_q <= issue;
            if (issue) begin
                pend_addr_q <= fetch_addr;
            end
            if (branch_i) begin
                fetch_addr <= branch_addr_i & WORD_MASK;
                count      <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (issue) begin
                    fetch_addr <= fetch_addr + WORD_STEP;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Payload storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            data_mem[wr_ptr] <= mem_rdata_i;
            addr_mem[wr_ptr] <= pend_addr_q;
        end
    end

endmodule

// File: tb/tb_mba_instr_prefetch.sv
// Bench for mba_instr_prefetch: queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mba_instr_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [15:0] branch_addr_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_rdata_o;
    logic [15:0] instr_addr_o;
    logic        busy_o;
    logic        mem_en_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_rdata_i = '0;

    int n_cmp = 0;
    int n_bad = 0;

    mba_instr_prefetch dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_rdata_o (instr_rdata_o),
        .instr_addr_o  (instr_addr_o),
        .busy_o        (busy_o),
        .mem_en_o      (mem_en_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [15:0] a);
        return {~a, a};
    endfunction

    // Memory returns a word derived from its address one cycle after the request.
    always @(posedge clk) begin
        mem_rdata_i <= mem_en_o ? data_of(mem_addr_o) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: FIFO as a queue of addresses, plus one outstanding request.
    logic [15:0] m_q[$];
    logic [15:0] m_faddr = 16'h8000;
    logic [15:0] m_paddr = '0;
    int          m_pend  = 0;
    bit          m_ok    = 1'b0;
    bit          exp_issue;

    always @(negedge clk) begin
        exp_issue = req_i && !branch_i && !rst && ((m_q.size() + m_pend) < 4);
        if (m_ok) begin
            chk("mem_en", 32'(mem_en_o), 32'(exp_issue));
            if (exp_issue) chk("mem_addr", 32'(mem_addr_o), 32'(m_faddr));
            chk("instr_valid", 32'(instr_valid_o), 32'(m_q.size() != 0));
            chk("busy", 32'(busy_o), 32'((m_pend != 0) || (m_q.size() != 0)));
            if (m_q.size() != 0) begin
                chk("head_addr", 32'(instr_addr_o), 32'(m_q[0]));
                chk("head_data", instr_rdata_o, data_of(m_q[0]));
            end
        end
        if (rst) begin
            m_q.delete();
            m_pend  = 0;
            m_faddr = 16'h8000;
            m_ok    = 1'b1;
        end else if (m_ok) begin
            if (branch_i) begin
                m_q.delete();
                m_pend  = 0;
                m_faddr = branch_addr_i & 16'hFFFC;
            end else begin
                if (m_q.size() != 0 && instr_ready_i) void'(m_q.pop_front());
                if (m_pend != 0) m_q.push_back(m_paddr);
                chk("fifo_bound", 32'(m_q.size() <= 4), 32'd1);
                m_pend = exp_issue ? 1 : 0;
                if (exp_issue) begin
                    m_paddr = m_faddr;
                    m_faddr = m_faddr + 16'd4;
                end
            end
        end
    end

    task automatic tick(input bit r, input bit q, input bit b, input logic [15:0] ba, input bit rd);
        @(posedge clk);
        #2;
        rst           = r;
        req_i         = q;
        branch_i      = b;
        branch_addr_i = ba;
        instr_ready_i = rd;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset, with req high in the last reset cycle to show mem_en is forced low.
        repeat (2) tick(1, 0, 0, 16'h0, 0);
        tick(1, 1, 0, 16'h0, 1);
        chk("rst_mem_en", 32'(mem_en_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);

        // Boot fetch stream
        tick(0, 1, 0, 16'h0, 1);
        chk("boot_c0_en", 32'(mem_en_o), 32'd1);
        chk("boot_c0_addr", 32'(mem_addr_o), 32'h8000);
        tick(0, 1, 0, 16'h0, 1);
        chk("boot_c1_addr", 32'(mem_addr_o), 32'h8004);
        chk("boot_c1_valid", 32'(instr_valid_o), 32'd0);
        tick(0, 1, 0, 16'h0, 1);
        chk("boot_c2_valid", 32'(instr_valid_o), 32'd1);
        chk("boot_c2_head", 32'(instr_addr_o), 32'h8000);
        chk("boot_c2_addr", 32'(mem_addr_o), 32'h8008);
        tick(0, 1, 0, 16'h0, 1);
        chk("boot_c3_head", 32'(instr_addr_o), 32'h8004);
        repeat (4) tick(0, 1, 0, 16'h0, 1);

        // Backpressure from a fresh reset
        repeat (2) tick(1, 0, 0, 16'h0, 0);
        for (int i = 0; i < 6; i++) begin
            tick(0, 1, 0, 16'h0, 0);
            if (i < 4) begin
                chk("bp_issue_en", 32'(mem_en_o), 32'd1);
                chk("bp_issue_addr", 32'(mem_addr_o), 32'h8000 + 32'(4 * i));
            end else begin
                chk("bp_stall_en", 32'(mem_en_o), 32'd0);
            end
        end
        chk("bp_head", 32'(instr_addr_o), 32'h8000);
        tick(0, 1, 0, 16'h0, 1);
        chk("bp_r0_en", 32'(mem_en_o), 32'd0);
        chk("bp_r0_head", 32'(instr_addr_o), 32'h8000);
        tick(0, 1, 0, 16'h0, 1);
        chk("bp_r1_addr", 32'(mem_addr_o), 32'h8010);
        chk("bp_r1_head", 32'(instr_addr_o), 32'h8004);
        tick(0, 1, 0, 16'h0, 1);
        tick(0, 1, 0, 16'h0, 1);
        chk("bp_r3_head", 32'(instr_addr_o), 32'h800C);
        tick(0, 1, 0, 16'h0, 1);
        chk("bp_r4_head", 32'(instr_addr_o), 32'h8010);
        repeat (3) tick(0, 1, 0, 16'h0, 1);

        // Redirect mid-stream: pop, pending response and branch coincide
        tick(0, 1, 1, 16'h0123, 1);
        chk("br_en", 32'(mem_en_o), 32'd0);
        tick(0, 1, 0, 16'h0, 1);
        chk("br1_addr", 32'(mem_addr_o), 32'h0120);
        chk("br1_valid", 32'(instr_valid_o), 32'd0);
        tick(0, 1, 0, 16'h0, 1);
        chk("br2_valid", 32'(instr_valid_o), 32'd0);
        tick(0, 1, 0, 16'h0, 1);
        chk("br3_head", 32'(instr_addr_o), 32'h0120);
        tick(0, 1, 0, 16'h0, 1);
        chk("br4_head", 32'(instr_addr_o), 32'h0124);

        // Address wrap
        tick(0, 1, 1, 16'hFFFE, 1);
        tick(0, 1, 0, 16'h0, 1);
        chk("wrap1_addr", 32'(mem_addr_o), 32'hFFFC);
        tick(0, 1, 0, 16'h0, 1);
        chk("wrap2_addr", 32'(mem_addr_o), 32'h0000);
        tick(0, 1, 0, 16'h0, 1);
        chk("wrap3_head", 32'(instr_addr_o), 32'hFFFC);
        tick(0, 1, 0, 16'h0, 1);
        chk("wrap4_head", 32'(instr_addr_o), 32'h0000);

        // Irregular ready and req patterns, checked by the model only
        for (int i = 0; i < 16; i++) tick(0, (i % 5) != 4, 0, 16'h0, (i % 3) != 0);
        for (int i = 0; i < 6; i++) tick(0, 1, 0, 16'h0, (i % 2) == 0);

        // req drop: last pending word still delivered, then idle
        tick(0, 1, 1, 16'h0200, 1);
        repeat (5) tick(0, 1, 0, 16'h0, 1);
        tick(0, 0, 0, 16'h0, 1);
        chk("drop_en", 32'(mem_en_o), 32'd0);
        tick(0, 0, 0, 16'h0, 1);
        chk("drop1_head", 32'(instr_addr_o), 32'h0210);
        chk("drop1_busy", 32'(busy_o), 32'd1);
        tick(0, 0, 0, 16'h0, 1);
        chk("drop2_busy", 32'(busy_o), 32'd0);
        chk("drop2_valid", 32'(instr_valid_o), 32'd0);
        tick(0, 0, 0, 16'h0, 1);

        // Reset mid-stream
        repeat (4) tick(0, 1, 0, 16'h0, 1);
        tick(1, 1, 0, 16'h0, 1);
        chk("mrst_en", 32'(mem_en_o), 32'd0);
        tick(0, 1, 0, 16'h0, 1);
        chk("mrst_valid", 32'(instr_valid_o), 32'd0);
        chk("mrst_busy", 32'(busy_o), 32'd0);
        chk("mrst_addr", 32'(mem_addr_o), 32'h8000);
        tick(0, 1, 0, 16'h0, 1);
        tick(0, 1, 0, 16'h0, 1);
        chk("mrst_head", 32'(instr_addr_o), 32'h8000);
        repeat (2) tick(0, 1, 0, 16'h0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
